// File: rtl/fifo_pkg.sv
// Shared types, default sizes and the rotate-priority search used by the
// FIFO write-side arbiter and any future read-side scheduler.
package fifo_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int DEF_NREQ      = 4;
    localparam int DEF_DWIDTH    = 8;
    localparam int DEF_MAX_BURST = 4;
    localparam int DEF_IDLE_TMO  = 8;

    localparam int MAX_NREQ   = 32;
    localparam int MAX_NREQ_W = $clog2(MAX_NREQ);

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

    // First set bit of req searching last_id+1 .. last_id+nreq, modulo nreq.
    // Iterating from the far end lets the nearest candidate overwrite the rest.
    function automatic int rr_next(input logic [MAX_NREQ-1:0] req,
                                   input int last_id,
                                   input int nreq);
        int pick;
        int idx;
        pick = 0;
        for (int k = MAX_NREQ; k >= 1; k--) begin
            if (k <= nreq) begin
                idx = (last_id + k) % nreq;
                if (req[idx[MAX_NREQ_W-1:0]]) begin
                    pick = idx;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester / FIFO write-port bundle. master drives the requests and the
// full flag; slave is the arbiter side.
interface fifo_wr_arbiter_if
    import fifo_pkg::*;
#(
    parameter int NREQ   = DEF_NREQ,
    parameter int DWIDTH = DEF_DWIDTH,
    parameter int ID_W   = id_width(NREQ)
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*DWIDTH-1:0] req_data;
    logic [NREQ-1:0]        req_last;
    logic [NREQ-1:0]        req_ready;
    logic                   wr_full;
    logic                   wren;
    logic [DWIDTH-1:0]      wdata;
    logic [ID_W-1:0]        gnt_id;
    logic                   gnt_active;

    modport master (
        output req_valid, req_data, req_last, wr_full,
        input  req_ready, wren, wdata, gnt_id, gnt_active
    );

    modport slave (
        input  req_valid, req_data, req_last, wr_full,
        output req_ready, wren, wdata, gnt_id, gnt_active
    );
endinterface

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin selector: nearest requester after last_id.
module rr_picker
    import fifo_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int ID_W = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] last_id,
    output logic [ID_W-1:0] next_id,
    output logic            any_req
);
    logic [MAX_NREQ-1:0] req_ext;

    always_comb begin
        req_ext = MAX_NREQ'(req);
        any_req = |req;
        next_id = ID_W'(rr_next(req_ext, int'(last_id), NREQ));
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one async-FIFO write port among NREQ
// requesters; one bubble cycle per grant, stalls cleanly on wr_full.
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int NREQ      = DEF_NREQ,
    parameter int DWIDTH    = DEF_DWIDTH,
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int IDLE_TMO  = DEF_IDLE_TMO
) (
    input  logic              wclk,
    input  logic              wrst_n,
    fifo_wr_arbiter_if.slave  bus
);
    localparam int ID_W   = id_width(NREQ);
    localparam int BEAT_W = cnt_width(MAX_BURST);
    localparam int TMO_W  = cnt_width(IDLE_TMO);

    arb_state_t        state, state_next;
    logic [ID_W-1:0]   gnt_id_q, gnt_id_next;
    logic [ID_W-1:0]   last_id, last_id_next;
    logic [ID_W-1:0]   pick_id;
    logic              gnt_active_q, gnt_active_next;
    logic [BEAT_W-1:0] beat_cnt, beat_cnt_next;
    logic [TMO_W-1:0]  tmo_cnt, tmo_cnt_next;
    logic              any_req;
    logic              owner_valid;
    logic              owner_last;
    logic              wren_int;
    logic              release_now;

    rr_picker #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) picker (
        .req     (bus.req_valid),
        .last_id (last_id),
        .next_id (pick_id),
        .any_req (any_req)
    );

    assign owner_valid    = bus.req_valid[gnt_id_q];
    assign owner_last     = bus.req_last[gnt_id_q];
    assign bus.wren       = wren_int;
    assign bus.gnt_id     = gnt_id_q;
    assign bus.gnt_active = gnt_active_q;

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            state        <= IDLE;
            gnt_id_q     <= '0;
            gnt_active_q <= 1'b0;
            last_id      <= ID_W'(NREQ - 1);
            beat_cnt     <= '0;
            tmo_cnt      <= '0;
        end else begin
            state        <= state_next;
            gnt_id_q     <= gnt_id_next;
            gnt_active_q <= gnt_active_next;
            last_id      <= last_id_next;
            beat_cnt     <= beat_cnt_next;
            tmo_cnt      <= tmo_cnt_next;
        end
    end

    // A full stall freezes both counters, so it can never force a release.
    always_comb begin
        state_next      = state;
        gnt_id_next     = gnt_id_q;
        gnt_active_next = gnt_active_q;
        last_id_next    = last_id;
        beat_cnt_next   = beat_cnt;
        tmo_cnt_next    = tmo_cnt;
        release_now     = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_next      = GRANT;
                    gnt_id_next     = pick_id;
                    gnt_active_next = 1'b1;
                    beat_cnt_next   = '0;
                    tmo_cnt_next    = '0;
                end
            end
            GRANT: begin
                if (wren_int) begin
                    beat_cnt_next = beat_cnt + BEAT_W'(1);
                    tmo_cnt_next  = '0;
                    release_now   = owner_last || (beat_cnt_next == BEAT_W'(MAX_BURST));
                end else if (!bus.wr_full) begin
                    tmo_cnt_next = tmo_cnt + TMO_W'(1);
                    release_now  = (tmo_cnt_next == TMO_W'(IDLE_TMO));
                end
                if (release_now) begin
                    state_next      = IDLE;
                    gnt_active_next = 1'b0;
                    last_id_next    = gnt_id_q;
                    beat_cnt_next   = '0;
                    tmo_cnt_next    = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        wren_int      = 1'b0;
        bus.wdata     = bus.req_data[int'(gnt_id_q)*DWIDTH +: DWIDTH];
        if (state == GRANT) begin
            bus.req_ready[gnt_id_q] = !bus.wr_full;
            wren_int                = owner_valid && !bus.wr_full;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed vector table, corner
// sequences, and a long random run against a behavioural reference model.
module tb_fifo_wr_arbiter;
    localparam int NREQ      = 4;
    localparam int DWIDTH    = 8;
    localparam int MAX_BURST = 4;
    localparam int IDLE_TMO  = 8;
    // An owner can stretch a grant by spacing beats IDLE_TMO-1 cycles apart.
    localparam int STARVE_LIMIT = NREQ * (MAX_BURST * IDLE_TMO + 1);

    typedef struct {
        logic            rst_n;
        logic [NREQ-1:0] valid;
        logic [NREQ-1:0] last;
        logic            full;
        logic            act;
        int              gid;
        logic            wren;
        logic [NREQ-1:0] ready;
    } vec_t;

    logic wclk = 1'b0;
    logic wrst_n;
    always #5 wclk = ~wclk;

    fifo_wr_arbiter_if #(.NREQ(NREQ), .DWIDTH(DWIDTH)) bus ();

    fifo_wr_arbiter #(
        .NREQ      (NREQ),
        .DWIDTH    (DWIDTH),
        .MAX_BURST (MAX_BURST),
        .IDLE_TMO  (IDLE_TMO)
    ) dut (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    logic            cur_rst_n;
    logic [NREQ-1:0] cur_valid, cur_last, acc_vec;
    logic            cur_full;
    int nxt_seq[NREQ];
    int wr_seq[NREQ];
    int words_per[NREQ];
    int wait_cnt[NREQ];
    int max_wait[NREQ];
    int grant_log[$];
    logic prev_act;
    int wren_total;

    // Reference model: owner is -1 while nobody holds the port.
    bit model_ok = 1'b0;
    int m_owner  = -1;
    int m_gid    = 0;
    int m_last   = NREQ - 1;
    int m_beats  = 0;
    int m_idle   = 0;

    function automatic logic [DWIDTH-1:0] word_of(input int id, input int seq);
        return DWIDTH'((id << 6) | (seq & 63));
    endfunction

    function automatic logic bit_at(input logic [NREQ-1:0] v, input int idx);
        return |(v & (NREQ'(1) << idx));
    endfunction

    function automatic logic [NREQ-1:0] put_bit(input logic [NREQ-1:0] v, input int idx, input logic b);
        logic [NREQ-1:0] m;
        m = NREQ'(1) << idx;
        return b ? (v | m) : (v & ~m);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic checkModel();
        logic [NREQ-1:0] exp_ready;
        logic            exp_wren;
        if (!model_ok) return;
        exp_ready = '0;
        exp_wren  = 1'b0;
        if (m_owner >= 0) begin
            exp_ready = NREQ'(!cur_full) << m_owner;
            exp_wren  = bit_at(cur_valid, m_owner) && !cur_full;
            check("m_wdata", bus.wdata, word_of(m_owner, nxt_seq[m_owner]));
        end
        check("inv_wren_full", bus.wren & bus.wr_full, 1'b0);
        check("m_gnt_active", bus.gnt_active, m_owner >= 0);
        check("m_gnt_id", bus.gnt_id, m_gid);
        check("m_req_ready", bus.req_ready, exp_ready);
        check("m_wren", bus.wren, exp_wren);
    endtask

    task automatic modelClock();
        int c;
        if (!cur_rst_n) begin
            m_owner  = -1;
            m_gid    = 0;
            m_last   = NREQ - 1;
            m_beats  = 0;
            m_idle   = 0;
            model_ok = 1'b1;
        end else if (m_owner < 0) begin
            for (int k = 1; k <= NREQ; k++) begin
                c = (m_last + k) % NREQ;
                if (m_owner < 0 && bit_at(cur_valid, c)) m_owner = c;
            end
            if (m_owner >= 0) begin
                m_gid   = m_owner;
                m_beats = 0;
                m_idle  = 0;
            end
        end else if (!cur_full) begin
            if (bit_at(cur_valid, m_owner)) begin
                m_beats++;
                m_idle = 0;
                if (bit_at(cur_last, m_owner) || m_beats == MAX_BURST) begin
                    m_last  = m_owner;
                    m_owner = -1;
                end
            end else begin
                m_idle++;
                if (m_idle == IDLE_TMO) begin
                    m_last  = m_owner;
                    m_owner = -1;
                end
            end
        end
    endtask

    // Called one time unit after a rising edge; returns before the falling edge.
    task automatic applyStimulus(input logic rst_n, input logic [NREQ-1:0] valid,
                                 input logic [NREQ-1:0] last, input logic full);
        logic [NREQ*DWIDTH-1:0] data;
        cur_rst_n = rst_n;
        cur_valid = valid;
        cur_last  = last;
        cur_full  = full;
        data = '0;
        for (int i = 0; i < NREQ; i++) begin
            data = data | ((NREQ*DWIDTH)'(word_of(i, nxt_seq[i])) << (i * DWIDTH));
        end
        wrst_n        = rst_n;
        bus.req_valid = valid;
        bus.req_last  = last;
        bus.wr_full   = full;
        bus.req_data  = data;
        #3;
        checkModel();
    endtask

    task automatic checkOutput(input string name, input logic act, input int gid,
                               input logic wren, input logic [NREQ-1:0] ready);
        check({name, ".gnt_active"}, bus.gnt_active, act);
        check({name, ".gnt_id"}, bus.gnt_id, gid);
        check({name, ".wren"}, bus.wren, wren);
        check({name, ".req_ready"}, bus.req_ready, ready);
    endtask

    task automatic advance();
        int id;
        acc_vec = cur_valid & bus.req_ready;
        if (bus.wren === 1'b1) begin
            id = int'(bus.gnt_id);
            check("sb_order", bus.wdata, word_of(id, wr_seq[id]));
            wr_seq[id]++;
            words_per[id]++;
            wren_total++;
        end
        if (bus.gnt_active === 1'b1 && prev_act !== 1'b1) grant_log.push_back(int'(bus.gnt_id));
        prev_act = bus.gnt_active;
        for (int i = 0; i < NREQ; i++) begin
            if (bit_at(acc_vec, i)) nxt_seq[i]++;
            if (bit_at(cur_valid, i) && !(bus.gnt_active === 1'b1 && int'(bus.gnt_id) == i)) begin
                if (!cur_full) wait_cnt[i]++;
            end else begin
                wait_cnt[i] = 0;
            end
            if (wait_cnt[i] > max_wait[i]) max_wait[i] = wait_cnt[i];
        end
        @(posedge wclk);
        modelClock();
        #1;
    endtask

    task automatic doReset();
        repeat (2) begin
            applyStimulus(1'b0, '0, '0, 1'b0);
            advance();
        end
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t            vecs[10];
        int              held;
        bit              done;
        logic [NREQ-1:0] rv, rl;

        wrst_n        = 1'b0;
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        bus.wr_full   = 1'b0;
        cur_rst_n     = 1'b0;
        cur_valid     = '0;
        cur_last      = '0;
        cur_full      = 1'b0;
        acc_vec       = '0;
        prev_act      = 1'b0;
        wren_total    = 0;
        for (int i = 0; i < NREQ; i++) begin
            nxt_seq[i]   = 0;
            wr_seq[i]    = 0;
            words_per[i] = 0;
            wait_cnt[i]  = 0;
            max_wait[i]  = 0;
        end
        @(posedge wclk);
        #1;

        //            rst   valid    last     full  act   gid wren  ready
        vecs[0] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 0, 1'b0, 4'b0000};
        vecs[1] = '{1'b1, 4'b0001, 4'b0000, 1'b0, 1'b0, 0, 1'b0, 4'b0000};
        vecs[2] = '{1'b1, 4'b0001, 4'b0000, 1'b0, 1'b1, 0, 1'b1, 4'b0001};
        vecs[3] = '{1'b1, 4'b0001, 4'b0000, 1'b0, 1'b1, 0, 1'b1, 4'b0001};
        vecs[4] = '{1'b1, 4'b0001, 4'b0001, 1'b0, 1'b1, 0, 1'b1, 4'b0001};
        vecs[5] = '{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 0, 1'b0, 4'b0000};
        vecs[6] = '{1'b1, 4'b0010, 4'b0000, 1'b0, 1'b0, 0, 1'b0, 4'b0000};
        vecs[7] = '{1'b1, 4'b0010, 4'b0000, 1'b1, 1'b1, 1, 1'b0, 4'b0000};
        vecs[8] = '{1'b1, 4'b0010, 4'b0010, 1'b0, 1'b1, 1, 1'b1, 4'b0010};
        vecs[9] = '{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1, 1'b0, 4'b0000};

        $display("[TB] directed vector table");
        doReset();
        for (int k = 0; k < 10; k++) begin
            applyStimulus(vecs[k].rst_n, vecs[k].valid, vecs[k].last, vecs[k].full);
            checkOutput($sformatf("vec%0d", k), vecs[k].act, vecs[k].gid, vecs[k].wren, vecs[k].ready);
            advance();
        end

        $display("[TB] all requesters continuous, no last");
        doReset();
        for (int i = 0; i < NREQ; i++) words_per[i] = 0;
        wren_total = 0;
        grant_log.delete();
        repeat (20) begin
            applyStimulus(1'b1, 4'b1111, 4'b0000, 1'b0);
            advance();
        end
        check("t2_words_total", wren_total, 16);
        for (int i = 0; i < NREQ; i++) check($sformatf("t2_words_req%0d", i), words_per[i], 4);
        repeat (2) begin
            applyStimulus(1'b1, 4'b1111, 4'b0000, 1'b0);
            advance();
        end
        check("t2_grant_count", grant_log.size(), 5);
        if (grant_log.size() == 5) begin
            for (int i = 0; i < 5; i++) check($sformatf("t2_order%0d", i), grant_log[i], i % NREQ);
        end

        $display("[TB] full stall mid-burst");
        doReset();
        for (int i = 0; i < NREQ; i++) words_per[i] = 0;
        applyStimulus(1'b1, 4'b0010, 4'b0000, 1'b0);
        checkOutput("t3_bubble", 1'b0, 0, 1'b0, 4'b0000);
        advance();
        repeat (2) begin
            applyStimulus(1'b1, 4'b0010, 4'b0000, 1'b0);
            advance();
        end
        repeat (5) begin
            applyStimulus(1'b1, 4'b0010, 4'b0000, 1'b1);
            checkOutput("t3_full", 1'b1, 1, 1'b0, 4'b0000);
            advance();
        end
        repeat (2) begin
            applyStimulus(1'b1, 4'b0010, 4'b0000, 1'b0);
            checkOutput("t3_resume", 1'b1, 1, 1'b1, 4'b0010);
            advance();
        end
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0);
        checkOutput("t3_release", 1'b0, 1, 1'b0, 4'b0000);
        advance();
        check("t3_words_req1", words_per[1], 4);

        $display("[TB] owner idle timeout");
        doReset();
        applyStimulus(1'b1, 4'b0100, 4'b0000, 1'b0);
        advance();
        applyStimulus(1'b1, 4'b0100, 4'b0000, 1'b0);
        checkOutput("t4_word", 1'b1, 2, 1'b1, 4'b0100);
        advance();
        held = 0;
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            applyStimulus(1'b1, 4'b1000, 4'b0000, 1'b0);
            if (bus.gnt_active === 1'b1 && bus.gnt_id === 2'd2) held++;
            else done = 1'b1;
            advance();
        end
        check("t4_hold_cycles", held, IDLE_TMO);
        applyStimulus(1'b1, 4'b1000, 4'b0000, 1'b0);
        checkOutput("t4_next_owner", 1'b1, 3, 1'b1, 4'b1000);
        advance();

        $display("[TB] reset during a burst");
        doReset();
        applyStimulus(1'b1, 4'b1100, 4'b0000, 1'b0);
        advance();
        applyStimulus(1'b1, 4'b1100, 4'b0000, 1'b0);
        checkOutput("t5_word", 1'b1, 2, 1'b1, 4'b0100);
        advance();
        applyStimulus(1'b0, 4'b1100, 4'b0000, 1'b0);
        advance();
        applyStimulus(1'b1, 4'b1001, 4'b0000, 1'b0);
        checkOutput("t5_after_reset", 1'b0, 0, 1'b0, 4'b0000);
        advance();
        applyStimulus(1'b1, 4'b1001, 4'b0000, 1'b0);
        checkOutput("t5_regrant", 1'b1, 0, 1'b1, 4'b0001);
        advance();

        $display("[TB] random traffic");
        doReset();
        for (int i = 0; i < NREQ; i++) begin
            wait_cnt[i] = 0;
            max_wait[i] = 0;
        end
        rv = '0;
        rl = '0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!bit_at(rv, i) && $urandom_range(0, 2) == 0) begin
                    rv = put_bit(rv, i, 1'b1);
                    rl = put_bit(rl, i, $urandom_range(0, 3) == 0);
                end
            end
            applyStimulus(1'b1, rv, rl, $urandom_range(0, 4) == 0);
            advance();
            for (int i = 0; i < NREQ; i++) begin
                if (bit_at(acc_vec, i)) begin
                    rv = put_bit(rv, i, $urandom_range(0, 3) != 0);
                    rl = put_bit(rl, i, $urandom_range(0, 3) == 0);
                end
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            check($sformatf("starve_req%0d", i), max_wait[i] <= STARVE_LIMIT, 1'b1);
            check($sformatf("sb_count_req%0d", i), wr_seq[i], nxt_seq[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
